// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host controller: FSM state encoding,
// keyboard protocol bytes and a small width helper.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_SEND_RST = 3'd0,
        ST_WAIT_TX  = 3'd1,
        ST_WAIT_ACK = 3'd2,
        ST_WAIT_BAT = 3'd3,
        ST_RUN      = 3'd4,
        ST_FAIL     = 3'd5
    } ps2_state_t;

    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] RSP_ACK      = 8'hFA;
    localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
    localparam logic [7:0] RSP_BAT_FAIL = 8'hFC;
    localparam logic [7:0] RSP_RESEND   = 8'hFE;

    // Bits needed to hold the values 0..n-1, never less than one.
    function automatic int unsigned width_for(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ps2_byte_fifo.sv
// Small byte FIFO for the scancode stream: wrap-around read/write pointers
// plus an occupancy count, synchronous flush, push accepted when full only
// if a pop happens in the same cycle.
module ps2_byte_fifo
    import ps2_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic       full,
    output logic       empty,
    output logic [7:0] head
);

    localparam int unsigned AW = width_for(DEPTH);
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push_ok;
    logic          pop_ok;

    // Handshake qualification; a pop frees the slot a same-cycle push needs.
    always_comb begin
        full    = (count == CNT_FULL);
        empty   = (count == '0);
        pop_ok  = pop && !empty;
        push_ok = push && (!full || pop_ok);
        head    = empty ? '0 : mem[rd_ptr];
    end

    // Pointer and occupancy bookkeeping; flush wins over any transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + AW'(1);
            if (pop_ok)
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok && !flush)
            mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/ps2_host_ctrl.sv
// PS/2 keyboard host controller: resets the keyboard, waits for ACK and the
// BAT result with a timeout and bounded retries, then forwards scancodes
// through a FIFO with a valid/ready stream.
module ps2_host_ctrl
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
    parameter int unsigned MAX_RETRIES    = 3,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_valid,
    input  logic [7:0] rx_byte,
    input  logic       rx_error,
    output logic       tx_start,
    output logic [7:0] tx_byte,
    input  logic       tx_busy,
    output logic       key_valid,
    output logic [7:0] key_code,
    input  logic       key_ready,
    output logic       kbd_ok,
    output logic       kbd_fail,
    output logic       overflow
);

    localparam int unsigned TW = width_for(TIMEOUT_CYCLES);
    localparam int unsigned RW = width_for(MAX_RETRIES + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRIES);

    ps2_state_t    state;
    logic [TW-1:0] timer;
    logic [RW-1:0] retry_cnt;

    logic timeout;
    logic retry_req;
    logic ack_ok;
    logic bat_ok;
    logic fifo_push;
    logic fifo_flush;
    logic fifo_full;
    logic fifo_empty;
    logic drop;
    logic [7:0] fifo_head;

    // Decode the keyboard response of the current cycle; a received byte
    // always displaces a coincident timeout.
    always_comb begin
        timeout   = (timer == TIMER_LAST);
        retry_req = 1'b0;
        ack_ok    = 1'b0;
        bat_ok    = 1'b0;
        case (state)
            ST_WAIT_ACK: begin
                if (rx_error)
                    retry_req = 1'b1;
                else if (rx_valid) begin
                    if (rx_byte == RSP_ACK)
                        ack_ok = 1'b1;
                    else if (rx_byte == RSP_RESEND)
                        retry_req = 1'b1;
                end else if (timeout)
                    retry_req = 1'b1;
            end
            ST_WAIT_BAT: begin
                if (rx_error)
                    retry_req = 1'b1;
                else if (rx_valid) begin
                    if (rx_byte == RSP_BAT_OK)
                        bat_ok = 1'b1;
                    else if (rx_byte == RSP_BAT_FAIL)
                        retry_req = 1'b1;
                end else if (timeout)
                    retry_req = 1'b1;
            end
            default: ;
        endcase
    end

    // Scancode path control: push only in RUN, flush whenever the keyboard
    // is being (re)initialised or a receive error kills the stream.
    always_comb begin
        fifo_push  = (state == ST_RUN) && rx_valid && !rx_error;
        fifo_flush = (state == ST_SEND_RST) || ((state == ST_RUN) && rx_error);
        drop       = fifo_push && fifo_full && !key_ready;
        key_valid  = !fifo_empty;
        key_code   = fifo_head;
    end

    // Initialisation / run FSM with registered status and transmit outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_SEND_RST;
            timer     <= '0;
            retry_cnt <= '0;
            tx_start  <= 1'b0;
            tx_byte   <= CMD_RESET;
            kbd_ok    <= 1'b0;
            kbd_fail  <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            case (state)
                ST_SEND_RST: begin
                    if (!tx_busy) begin
                        tx_start <= 1'b1;
                        tx_byte  <= CMD_RESET;
                        state    <= ST_WAIT_TX;
                    end
                end
                ST_WAIT_TX: begin
                    // Skip the cycle tx_start is still high so the
                    // transmitter has a chance to raise tx_busy first.
                    if (!tx_start && !tx_busy) begin
                        timer <= '0;
                        state <= ST_WAIT_ACK;
                    end
                end
                ST_WAIT_ACK, ST_WAIT_BAT: begin
                    if (retry_req) begin
                        if (retry_cnt == RETRY_MAX) begin
                            state    <= ST_FAIL;
                            kbd_fail <= 1'b1;
                        end else begin
                            retry_cnt <= retry_cnt + RW'(1);
                            state     <= ST_SEND_RST;
                        end
                        kbd_ok   <= 1'b0;
                        overflow <= 1'b0;
                    end else if (ack_ok) begin
                        timer <= '0;
                        state <= ST_WAIT_BAT;
                    end else if (bat_ok) begin
                        kbd_ok <= 1'b1;
                        state  <= ST_RUN;
                    end else if (timer != TIMER_LAST) begin
                        // Saturating: a byte that displaced the timeout
                        // leaves it pending for the next cycle.
                        timer <= timer + TW'(1);
                    end
                end
                ST_RUN: begin
                    if (rx_error) begin
                        retry_cnt <= '0;
                        kbd_ok    <= 1'b0;
                        overflow  <= 1'b0;
                        state     <= ST_SEND_RST;
                    end else if (drop) begin
                        overflow <= 1'b1;
                    end
                end
                ST_FAIL: ;
                default: state <= ST_SEND_RST;
            endcase
        end
    end

    ps2_byte_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (fifo_flush),
        .push     (fifo_push),
        .push_data(rx_byte),
        .pop      (key_ready),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head     (fifo_head)
    );

endmodule

// File: tb/tb_ps2_host_ctrl.sv
// Self-checking bench for ps2_host_ctrl with a short timeout.
module tb_ps2_host_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       rx_error = 1'b0;
    logic       tx_start;
    logic [7:0] tx_byte;
    logic       tx_busy = 1'b0;
    logic       key_valid;
    logic [7:0] key_code;
    logic       key_ready = 1'b0;
    logic       kbd_ok;
    logic       kbd_fail;
    logic       overflow;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int tx_cnt = 0;
    int tx_times[$];
    logic tx_model_en = 1'b1;

    typedef struct {
        logic       rxv;
        logic [7:0] rxb;
        logic       kr;
        logic       ekv;
        logic [7:0] ekc;
        logic       eov;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs[NV];

    ps2_host_ctrl #(
        .TIMEOUT_CYCLES(50),
        .MAX_RETRIES   (3),
        .FIFO_DEPTH    (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_valid (rx_valid),
        .rx_byte  (rx_byte),
        .rx_error (rx_error),
        .tx_start (tx_start),
        .tx_byte  (tx_byte),
        .tx_busy  (tx_busy),
        .key_valid(key_valid),
        .key_code (key_code),
        .key_ready(key_ready),
        .kbd_ok   (kbd_ok),
        .kbd_fail (kbd_fail),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic rxv, input logic [7:0] rxb, input logic kr,
                                input logic ekv, input logic [7:0] ekc, input logic eov);
        vec_t v;
        v.rxv = rxv; v.rxb = rxb; v.kr = kr;
        v.ekv = ekv; v.ekc = ekc; v.eov = eov;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Transmit monitor: counts start pulses and checks each one.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (tx_start === 1'b1) begin
                tx_cnt++;
                tx_times.push_back(cyc);
                chk("tx_start_while_busy", {31'd0, tx_busy}, 32'd0);
                chk("tx_byte_cmd", {24'd0, tx_byte}, 32'hFF);
            end
        end
    end

    // Transmitter model: busy for five cycles starting after the start pulse.
    initial begin
        forever begin
            @(negedge clk);
            if (tx_model_en && tx_start === 1'b1) begin
                @(posedge clk); #1 tx_busy = 1'b1;
                repeat (5) @(posedge clk);
                #1 tx_busy = 1'b0;
            end
        end
    end

    task automatic do_reset(input string tag);
        @(posedge clk); #2;
        rst = 1'b1; rx_valid = 1'b0; rx_error = 1'b0; key_ready = 1'b0;
        #1;
        chk({tag, "_rst_tx_start"},  {31'd0, tx_start},  32'd0);
        chk({tag, "_rst_tx_byte"},   {24'd0, tx_byte},   32'hFF);
        chk({tag, "_rst_key_valid"}, {31'd0, key_valid}, 32'd0);
        chk({tag, "_rst_key_code"},  {24'd0, key_code},  32'h00);
        chk({tag, "_rst_kbd_ok"},    {31'd0, kbd_ok},    32'd0);
        chk({tag, "_rst_kbd_fail"},  {31'd0, kbd_fail},  32'd0);
        chk({tag, "_rst_overflow"},  {31'd0, overflow},  32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_tx(input string name, input int bound);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (tx_start === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        chk(name, {31'd0, seen}, 32'd1);
    endtask

    task automatic send_rx(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1; rx_byte = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic pulse_rx_error();
        @(negedge clk);
        rx_error = 1'b1;
        @(negedge clk);
        rx_error = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

    initial begin
        int n0;
        int g;

        // Full-FIFO push+pop, then overflow and drain.
        vecs[0]  = mk(1'b1, 8'h11, 1'b0, 1'b1, 8'h11, 1'b0);
        vecs[1]  = mk(1'b1, 8'hAA, 1'b0, 1'b1, 8'h11, 1'b0);
        vecs[2]  = mk(1'b1, 8'h22, 1'b0, 1'b1, 8'h11, 1'b0);
        vecs[3]  = mk(1'b1, 8'h33, 1'b0, 1'b1, 8'h11, 1'b0);
        vecs[4]  = mk(1'b1, 8'h44, 1'b1, 1'b1, 8'hAA, 1'b0);
        vecs[5]  = mk(1'b0, 8'h00, 1'b1, 1'b1, 8'h22, 1'b0);
        vecs[6]  = mk(1'b0, 8'h00, 1'b1, 1'b1, 8'h33, 1'b0);
        vecs[7]  = mk(1'b0, 8'h00, 1'b1, 1'b1, 8'h44, 1'b0);
        vecs[8]  = mk(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
        vecs[9]  = mk(1'b1, 8'h1C, 1'b0, 1'b1, 8'h1C, 1'b0);
        vecs[10] = mk(1'b1, 8'hF0, 1'b0, 1'b1, 8'h1C, 1'b0);
        vecs[11] = mk(1'b1, 8'h1C, 1'b0, 1'b1, 8'h1C, 1'b0);
        vecs[12] = mk(1'b1, 8'h32, 1'b0, 1'b1, 8'h1C, 1'b0);
        vecs[13] = mk(1'b1, 8'h21, 1'b0, 1'b1, 8'h1C, 1'b1);
        vecs[14] = mk(1'b0, 8'h00, 1'b1, 1'b1, 8'hF0, 1'b1);
        vecs[15] = mk(1'b0, 8'h00, 1'b1, 1'b1, 8'h1C, 1'b1);
        vecs[16] = mk(1'b0, 8'h00, 1'b1, 1'b1, 8'h32, 1'b1);
        vecs[17] = mk(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1);

        // Normal bring-up: ACK then BAT ok.
        do_reset("init");
        n0 = tx_cnt;
        wait_tx("init_tx", 20);
        repeat (10) @(negedge clk);
        send_rx(8'hFA);
        repeat (2) @(negedge clk);
        send_rx(8'hAA);
        repeat (2) @(negedge clk);
        chk("init_kbd_ok", {31'd0, kbd_ok}, 32'd1);
        chk("init_key_valid", {31'd0, key_valid}, 32'd0);
        chk("init_tx_count", tx_cnt - n0, 32'd1);
        chk("init_kbd_fail", {31'd0, kbd_fail}, 32'd0);

        // Scancode stream vectors.
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            rx_valid = vecs[i].rxv; rx_byte = vecs[i].rxb; key_ready = vecs[i].kr;
            @(posedge clk); #1;
            chk($sformatf("vec%0d_key_valid", i), {31'd0, key_valid}, {31'd0, vecs[i].ekv});
            chk($sformatf("vec%0d_key_code", i),  {24'd0, key_code},  {24'd0, vecs[i].ekc});
            chk($sformatf("vec%0d_overflow", i),  {31'd0, overflow},  {31'd0, vecs[i].eov});
            chk($sformatf("vec%0d_kbd_ok", i),    {31'd0, kbd_ok},    32'd1);
        end
        @(negedge clk);
        rx_valid = 1'b0; key_ready = 1'b0;

        // Receive error while running: flush and re-initialise.
        send_rx(8'h5A);
        chk("err_pre_key_valid", {31'd0, key_valid}, 32'd1);
        pulse_rx_error();
        chk("err_key_valid", {31'd0, key_valid}, 32'd0);
        chk("err_kbd_ok", {31'd0, kbd_ok}, 32'd0);
        chk("err_overflow", {31'd0, overflow}, 32'd0);
        n0 = tx_cnt;
        wait_tx("err_tx", 20);
        repeat (10) @(negedge clk);
        send_rx(8'hFA);
        repeat (2) @(negedge clk);
        send_rx(8'hAA);
        repeat (2) @(negedge clk);
        chk("err_kbd_ok_again", {31'd0, kbd_ok}, 32'd1);
        chk("err_tx_count", tx_cnt - n0, 32'd1);

        // Resend request, then ACK arriving exactly on the timeout cycle.
        tx_model_en = 1'b0;
        do_reset("resend");
        n0 = tx_cnt;
        wait_tx("resend_tx1", 20);
        repeat (5) @(negedge clk);
        send_rx(8'hFE);
        wait_tx("resend_tx2", 20);
        repeat (51) @(negedge clk);
        rx_valid = 1'b1; rx_byte = 8'hFA;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (20) @(negedge clk);
        chk("resend_tx_count", tx_cnt - n0, 32'd2);
        send_rx(8'hAA);
        @(negedge clk);
        chk("resend_kbd_ok", {31'd0, kbd_ok}, 32'd1);

        // Reset during WAIT_BAT abandons the handshake.
        tx_model_en = 1'b1;
        pulse_rx_error();
        wait_tx("bat_tx", 20);
        repeat (10) @(negedge clk);
        send_rx(8'hFA);
        repeat (3) @(negedge clk);
        do_reset("bat");
        n0 = tx_cnt;
        repeat (40) @(negedge clk);
        chk("bat_tx_count", tx_cnt - n0, 32'd1);
        chk("bat_kbd_ok", {31'd0, kbd_ok}, 32'd0);

        // No replies at all: four attempts, then permanent failure.
        do_reset("fail");
        tx_times.delete();
        n0 = tx_cnt;
        repeat (400) @(negedge clk);
        chk("fail_tx_count", tx_cnt - n0, 32'd4);
        if (tx_times.size() == 4) begin
            for (int i = 1; i < 4; i++) begin
                g = tx_times[i] - tx_times[i-1];
                chk($sformatf("fail_gap%0d", i), {31'd0, (g >= 55 && g <= 65)}, 32'd1);
            end
        end
        chk("fail_kbd_fail", {31'd0, kbd_fail}, 32'd1);
        chk("fail_kbd_ok", {31'd0, kbd_ok}, 32'd0);
        send_rx(8'hFA);
        repeat (2) @(negedge clk);
        send_rx(8'hAA);
        repeat (60) @(negedge clk);
        chk("fail_sticky", {31'd0, kbd_fail}, 32'd1);
        chk("fail_ok_stays_low", {31'd0, kbd_ok}, 32'd0);
        chk("fail_no_more_tx", tx_cnt - n0, 32'd4);
        chk("fail_key_valid", {31'd0, key_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ps2_host_ctrl.md
PS2_HOST_CTRL -- requirements
Module: ps2_host_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1_000_000, clk cycles to wait for a keyboard response.
REQ-002 SHALL have parameter MAX_RETRIES, default 3, number of reset attempts before declaring failure.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, a power of two, scancode buffer depth.
REQ-004 clk  in  1  system clock; all logic on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 rx_valid  in  1  one-cycle pulse: receiver delivered a byte (already clk-synchronous).
REQ-007 rx_byte  in  8  received byte, valid with rx_valid.
REQ-008 rx_error  in  1  one-cycle pulse: receiver parity/framing error (receiver reset_required).
REQ-009 tx_start  out  1  one-cycle pulse: transmitter sends tx_byte.
REQ-010 tx_byte  out  8  command byte to transmitter.
REQ-011 tx_busy  in  1  transmitter busy with a host-to-device frame.
REQ-012 key_valid / key_code / key_ready  out 1 / out 8 / in 1  scancode stream, valid/ready handshake.
REQ-013 kbd_ok  out  1  keyboard initialised, scancodes flowing.
REQ-014 kbd_fail  out  1  retries exhausted, sticky until rst.
REQ-015 overflow  out  1  sticky: scancode dropped because FIFO full.

Function
REQ-016 SHALL implement states SEND_RST, WAIT_TX, WAIT_ACK, WAIT_BAT, RUN, FAIL.
REQ-017 SEND_RST: when tx_busy=0, pulse tx_start one cycle with tx_byte=0xFF, go WAIT_TX; else hold.
REQ-018 WAIT_TX: when tx_busy=0 (transmitter done), clear timer, go WAIT_ACK.
REQ-019 WAIT_ACK: rx_byte 0xFA -> WAIT_BAT (timer cleared); 0xFE -> SEND_RST, retry count incremented; other bytes ignored.
REQ-020 WAIT_BAT: rx_byte 0xAA -> RUN; 0xFC -> retry; other bytes ignored.
REQ-021 Timer SHALL count clk cycles in WAIT_ACK/WAIT_BAT; reaching TIMEOUT_CYCLES-1 -> retry.
REQ-022 Retry: if retry count equals MAX_RETRIES go FAIL, else increment and go SEND_RST.
REQ-023 rx_valid in the same cycle as timeout SHALL win; the timeout is discarded.
REQ-024 rx_error in WAIT_ACK/WAIT_BAT SHALL count as a retry; in RUN SHALL flush FIFO, clear retry count, go SEND_RST.
REQ-025 RUN: every rx_valid byte (including 0xAA) pushed to FIFO; push while full drops byte, sets overflow.
REQ-026 Simultaneous push and pop when full SHALL both succeed, no overflow.
REQ-027 key_valid=1 whenever FIFO non-empty; key_code = head; pop on key_valid&key_ready.
REQ-028 Entering SEND_RST SHALL flush FIFO, clear overflow, deassert kbd_ok.
REQ-029 kbd_ok=1 only in RUN; kbd_fail=1 only in FAIL; FAIL exits only by rst; rx ignored in FAIL.
REQ-030 tx_start SHALL never be asserted while tx_busy=1.

Reset
REQ-031 rst SHALL asynchronously force state SEND_RST, retry count 0, timer 0, FIFO empty.
REQ-032 Reset values: tx_start=0, tx_byte=0xFF, key_valid=0, key_code=0x00, kbd_ok=0, kbd_fail=0, overflow=0.
REQ-033 rst mid-frame or mid-handshake SHALL abandon it; sequence restarts at SEND_RST after release.

Structure
REQ-034 Shared package ps2_pkg SHALL hold state encoding and constants CMD_RESET=0xFF, RSP_ACK=0xFA, RSP_BAT_OK=0xAA, RSP_BAT_FAIL=0xFC, RSP_RESEND=0xFE.
REQ-035 FIFO SHALL be sub-module ps2_byte_fifo (8-bit, FIFO_DEPTH, flush input, wrap-around pointers plus count).

Verification (TIMEOUT_CYCLES=50, MAX_RETRIES=3, FIFO_DEPTH=4)
REQ-036 Release rst, tx_busy idle, reply 0xFA then 0xAA -> one tx_start with 0xFF, kbd_ok=1, no key_valid.
REQ-037 No replies -> exactly 4 tx_start pulses ~50 cycles apart, then kbd_fail=1 permanently.
REQ-038 In RUN, push 0x1C,0xF0,0x1C,0x32,0x21 with key_ready=0 -> key_code 0x1C held, overflow=1; drain yields 0x1C,0xF0,0x1C,0x32.
REQ-039 In RUN, rx_error pulse -> FIFO flushed, kbd_ok=0, new 0xFF sent, normal ACK/BAT returns kbd_ok=1.
REQ-040 WAIT_ACK: reply 0xFE -> resend 0xFF; rx_valid 0xFA on timeout cycle -> WAIT_BAT, no extra tx_start.
REQ-041 Assert rst during WAIT_BAT -> all outputs at reset values immediately; single 0xFF sent after release.
